// File: rtl/macc_drain.sv
// Output stage after the MAC array: captures a vector of ACC-format results and streams the
// lanes out one per handshake, each requantized to ACT format. Optional: MACC_DRAIN_SAT_CNT_EN.
module macc_drain #(
    parameter int NUM_PE = 16,
    parameter int ACT_QM = 8,
    parameter int ACT_QN = 8,
    parameter int ACC_QM = 16,
    parameter int ACC_QN = 16,
    localparam int ACT_BW = ACT_QM + ACT_QN,
    localparam int ACC_BW = ACC_QM + ACC_QN,
    localparam int LW     = $clog2(NUM_PE + 2)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cap_valid,
    output logic                           cap_ready,
    input  logic [NUM_PE:0][ACC_BW-1:0]    din_acc,
    input  logic [LW-1:0]                  num_lanes,
    input  logic                           relu_en,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic [ACT_BW-1:0]              dout_act,
    output logic [LW-1:0]                  dout_idx,
    output logic                           dout_last,
    output logic                           busy
`ifdef MACC_DRAIN_SAT_CNT_EN
    ,
    input  logic                           sat_clr,
    output logic [15:0]                    sat_cnt
`endif
);
    localparam int SH = ACC_QN - ACT_QN;
    localparam logic signed [ACC_BW:0] RND  = (ACC_BW+1)'(2 ** (SH - 1));
    localparam logic signed [ACC_BW:0] SMAX = (ACC_BW+1)'(2 ** (ACT_BW - 1) - 1);
    localparam logic signed [ACC_BW:0] SMIN = ~SMAX;
    localparam logic [LW-1:0]          FULL = LW'(NUM_PE + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                     state_q, state_d;
    logic [NUM_PE:0][ACC_BW-1:0] buf_q, buf_d;
    logic                       relu_q, relu_d;
    logic [LW-1:0]              n_q, n_d, idx_q, idx_d;
    logic [ACT_BW-1:0]          act_q, act_d;
    logic                       last_q, last_d, valid_q, valid_d, sat_q, sat_d;

    logic                       xfer, cap;
    logic [LW-1:0]              n_eff, idx_nxt;
    logic [ACC_BW-1:0]          sel;
    logic                       relu_sel, sat_lane;
    logic signed [ACC_BW:0]     ext, t, s, clip;
    logic [ACT_BW-1:0]          q_act;

    // One lane mux feeding one requant unit; the lane is whichever loads the output register next.
    always_comb begin
        xfer      = valid_q && dout_ready;
        cap_ready = (state_q == IDLE) || (xfer && last_q);
        cap       = cap_valid && cap_ready;
        n_eff     = (num_lanes == '0 || num_lanes > FULL) ? FULL : num_lanes;
        idx_nxt   = idx_q + LW'(1);
        sel       = cap ? din_acc[0] : buf_q[idx_nxt];
        relu_sel  = cap ? relu_en : relu_q;

        ext      = $signed({sel[ACC_BW-1], sel});
        t        = ext + RND;
        s        = t >>> SH;
        clip     = s;
        sat_lane = 1'b0;
        if (s > SMAX) begin
            clip     = SMAX;
            sat_lane = 1'b1;
        end else if (s < SMIN) begin
            clip     = SMIN;
            sat_lane = 1'b1;
        end
        q_act = clip[ACT_BW-1:0];
        if (relu_sel && q_act[ACT_BW-1]) q_act = '0;
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        relu_d  = relu_q;
        n_d     = n_q;
        idx_d   = idx_q;
        act_d   = act_q;
        last_d  = last_q;
        valid_d = valid_q;
        sat_d   = sat_q;
        if (cap) begin
            state_d = DRAIN;
            buf_d   = din_acc;
            relu_d  = relu_en;
            n_d     = n_eff;
            idx_d   = '0;
            act_d   = q_act;
            last_d  = (n_eff == LW'(1));
            valid_d = 1'b1;
            sat_d   = sat_lane;
        end else if (xfer) begin
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end else begin
                idx_d  = idx_nxt;
                act_d  = q_act;
                last_d = (idx_nxt == n_q - LW'(1));
                sat_d  = sat_lane;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            buf_q   <= '0;
            relu_q  <= 1'b0;
            n_q     <= '0;
            idx_q   <= '0;
            act_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            relu_q  <= relu_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            act_q   <= act_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign dout_valid = valid_q;
    assign dout_act   = act_q;
    assign dout_idx   = idx_q;
    assign dout_last  = last_q;
    assign busy       = (state_q == DRAIN);

`ifdef MACC_DRAIN_SAT_CNT_EN
    logic [15:0] sat_cnt_q, sat_cnt_d;

    // Counts clipped lanes as they are accepted downstream; ReLU zeroing is not a clip.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) sat_cnt_d = '0;
        else if (xfer && sat_q && sat_cnt_q != 16'hFFFF) sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= '0;
        else     sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`else
    logic sat_unused;
    assign sat_unused = sat_q;
`endif
endmodule

// File: doc/macc_drain.md
Name: macc_drain

Overview:
- Output stage directly downstream of the PE-array multiply-accumulate block.
- Captures its full vector of NUM_PE+1 signed ACC-format results in one cycle, then streams them out one lane per handshake.
- Each lane is requantized from ACC (QM.QN) to ACT format, with optional ReLU, so results can be written back to the activation buffer.
- Decouples the array from a narrow, backpressured writeback path.

Parameters:
NUM_PE, 16, number of PE lanes; captured vector has NUM_PE+1 entries (lane NUM_PE = chain accumulator)
ACT_QM, 8, output integer bits
ACT_QN, 8, output fractional bits
ACC_QM, 16, input integer bits
ACC_QN, 16, input fractional bits (must satisfy ACC_QN > ACT_QN)
(derived, not overridable: ACT_BW=ACT_QM+ACT_QN, ACC_BW=ACC_QM+ACC_QN, LW=$clog2(NUM_PE+2))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
cap_valid  in  1  din_acc vector valid
cap_ready  out  1  block can capture a vector this cycle
din_acc  in  ACC_BW x (NUM_PE+1) signed  accumulator vector from the MAC array
num_lanes  in  LW  lanes to emit; sampled at capture
relu_en  in  1  clamp negative results to 0; sampled at capture
dout_valid  out  1  dout_act/dout_idx/dout_last valid
dout_ready  in  1  consumer accepts
dout_act  out  ACT_BW signed  requantized lane value
dout_idx  out  LW-1..0 (LW bits)  lane index of dout_act
dout_last  out  1  final lane of the captured vector
busy  out  1  vector held (state DRAIN)

Behaviour:
- Reset (async assert, sync release): state IDLE; dout_valid=0, dout_act=0, dout_idx=0, dout_last=0, busy=0; vector buffer cleared; cap_ready=1 after release.
- States:
  - IDLE: cap_ready=1. On cap_valid: latch din_acc into buffer, latch relu_en, latch effective lane count N, go to DRAIN.
  - DRAIN: emit lanes 0..N-1 in order.
- Effective lane count: N = num_lanes if 1 <= num_lanes <= NUM_PE+1, otherwise N = NUM_PE+1 (values 0 and out-of-range both map to the full vector).
- Latency: capture at edge E; dout_valid=1 with lane 0 from edge E+1 (registered output).
- Handshake:
  - Transfer occurs when dout_valid && dout_ready.
  - On transfer of lane i<N-1, lane i+1 is presented at the next edge; no bubbles.
  - While dout_valid && !dout_ready, dout_act/dout_idx/dout_last hold stable.
  - dout_valid never drops without a transfer, except on reset.
- dout_last=1 exactly while dout_idx==N-1.
- End of vector (transfer with dout_last):
  - If cap_valid is also high that cycle, cap_ready=1 (combinational), the new vector is captured, and its lane 0 appears at the next edge (back-to-back, no gap).
  - Otherwise return to IDLE with dout_valid=0.
- cap_ready=0 at all other times in DRAIN; cap_valid there is ignored and din_acc is not sampled.
- Requantization per lane, using ACC_BW+1-bit intermediate:
  - t = x + 2^(ACC_QN-ACT_QN-1) (round half toward +inf).
  - s = t >>> (ACC_QN-ACT_QN) (arithmetic shift).
  - Saturate s to [-2^(ACT_BW-1), 2^(ACT_BW-1)-1].
  - If latched relu_en and result < 0, output 0.
- Requant logic runs on the lane selected for the next output register load (one lane mux + one requant unit, not NUM_PE+1 copies).
- Reset during DRAIN: drain abandoned immediately; outputs go to reset values asynchronously.

Optional Feature:
MACC_DRAIN_SAT_CNT_EN
- Defined:
  - Adds ports sat_clr (in, 1) and sat_cnt (out, 16).
  - sat_cnt increments on each transferred lane whose value was clipped by saturation (ReLU clamping does not count).
  - sat_cnt saturates at 0xFFFF; it does not wrap.
  - sat_clr zeroes it synchronously and wins over a simultaneous increment.
  - Reset value 0.
- Undefined: ports and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with random inputs -> dout_valid=0, dout_act=0, busy=0 immediately; cap_ready=1 after release.
- Full drain: din_acc[k]=k<<16, num_lanes=0, dout_ready=1 -> 17 outputs at consecutive cycles starting 1 cycle after capture, dout_act=k<<8, dout_idx=k, dout_last only at idx 16.
- Rounding: lane values 0x00000080, 0x0000007F, 0xFFFFFF80, 0xFFFFFF7F with num_lanes=4 -> 0x0001, 0x0000, 0x0000, 0xFFFF.
- Saturation/ReLU: 0x7FFFFFFF, 0x80000000 -> 0x7FFF, 0x8000 with relu_en=0; with relu_en=1 -> 0x7FFF, 0x0000 (sat_cnt=2 per vector when macro defined, regardless of relu_en).
- Backpressure/back-to-back: num_lanes=3, dout_ready pattern 0,1,0,1,1 with cap_valid held high -> outputs stable while stalled; cap_ready=1 only in last-lane transfer cycle; second vector lane 0 appears next cycle.
- Reset mid-drain: rst pulsed while dout_idx=5 -> dout_valid=0 at once; a new capture after release starts at idx 0 with new data.
